bsg_test_node_client_mem: RTL and testbench
===========================================

# bsg_test_node_client_mem

Far-end FSB test client for the two-manycore test ring. It accepts request packets from the FSB master test node and services stores and loads against a private synchronous memory. It returns exactly one response packet per request to the master. It acts as a deterministic memory target, so the ring, the FSB adapter and credit return can be exercised without a full manycore behind them.

## Interface
- ring_width_p, 80, FSB ring packet width
- master_id_p, 0, FSB dest id stamped on every response
- client_id_p, 1, FSB id this node answers to
- data_width_p, 32, data field width
- addr_width_p, 10, word address field width
- els_p, 1024, memory depth in words; power of two, ≤ 2^addr_width_p
- tag_width_p, 8, request tag echoed in the response
- clk_i  in  1  clock
- reset_n_i  in  1  reset; one clock, asynchronous, active-low
- en_i  in  1  when low, new requests are not accepted; an in-flight response still completes
- v_i  in  1  request valid
- data_i  in  ring_width_p  request packet
- ready_o  out  1  request accepted when v_i & ready_o
- v_o  out  1  response valid
- data_o  out  ring_width_p  response packet
- yumi_i  in  1  response consumed; legal only while v_o=1
- err_cnt_o  out  8  saturating count of malformed requests

## Operation
- Packet layout, from MSB down:
  - dest id, 4 bits
  - cmd, 1 bit
  - payload
- Payload layout, from its LSB up:
  - data, data_width_p bits
  - addr, addr_width_p bits
  - tag, tag_width_p bits
  - op, 2 bits
- Payload bits above op are ignored on input and driven 0 on output. Legality: 5+2+tag+addr+data ≤ ring_width_p.
- Op codes:
  - 00 = store
  - 01 = load, and load response
  - 10 = store ack
  - 11 = error
- A request is malformed if any of these hold:
  - dest ≠ client_id_p
  - cmd = 1
  - op ∈ {10, 11}
  - addr ≥ els_p
- Store: mem[addr] ← data. Response: op=10, tag echoed, addr echoed, data=0.
- Load: response op=01, tag echoed, addr echoed, data=mem[addr].
- Every response carries dest=master_id_p and cmd=0.
- FSM states:
  - IDLE: ready_o=en_i.
    - Accepted store → RESP.
    - Accepted load → READ.
    - Accepted malformed request → see Configuration.
  - READ: ready_o=0. Memory output is registered into the response data; next state RESP.
  - RESP: v_o=1 and data_o is held stable. yumi_i → IDLE.
- Single outstanding request; no bypass from RESP to a new acceptance in the same cycle.
- err_cnt_o increments by 1 for each accepted malformed request and saturates at 255.
- Memory contents are not reset.

## Timing
- Reset (reset_n_i=0): state IDLE, v_o=0, ready_o=0, data_o=0, err_cnt_o=0. These hold immediately and asynchronously. After release, ready_o follows en_i.
- Reset mid-response: the response is lost and no retransmit occurs. Stores already written remain in memory.
- Store accepted in cycle N: memory written at the end of N; v_o=1 from N+1.
- Load accepted in cycle N: v_o=1 from N+2.
- yumi_i in cycle M: v_o=0 and ready_o=en_i in M+1. Earliest next acceptance is M+1.
- Minimum period per request: 2 cycles for stores, 3 cycles for loads, each assuming yumi_i is asserted the first cycle v_o is high.
- A load following a store to the same addr returns the new data; the write completes before the read is issued.
- en_i falling while in READ/RESP: the response still completes, then ready_o stays 0.

## Configuration
- BSG_TEST_NODE_CLIENT_ERR_RESP_EN
  - Defined: a malformed request produces a response with op=11, tag echoed, addr echoed, data=0. Flow goes IDLE→RESP. Memory is untouched.
  - Undefined: a malformed request is consumed and silently dropped; the FSM stays in IDLE. Only err_cnt_o changes.

## Structure
- bsg_test_node_pkg holds:
  - op code enum
  - payload struct macro parameterized by data/addr/tag widths
  - FSB header field widths (dest 4, cmd 1)
- Storage uses sub-module bsg_mem_1rw_sync (width data_width_p, els_p).
- The FSM, response register and error counter live in the top module.

## Test plan
- Store addr=0x005 data=0xDEADBEEF tag=0x11: v_o at N+1; data_o has op=10, tag=0x11, addr=0x005, data=0, dest=master_id_p.
- Load addr=0x005 tag=0x22 issued right after the store's yumi_i: response op=01, data=0xDEADBEEF, tag=0x22, v_o at N+2.
- Backpressure: hold yumi_i=0 for 10 cycles. v_o and data_o stay stable and ready_o=0 throughout; after yumi_i, ready_o=1 the next cycle.
- Malformed requests: dest=client_id_p+1, then addr=els_p, then op=11. err_cnt_o reaches 3. With ERR_RESP_EN, three op=11 responses are observed; without it, v_o never rises.
- Stream of 300 malformed requests: err_cnt_o saturates at 255.
- Pull reset_n_i low while in RESP: v_o drops immediately; after release, ready_o=en_i and a load of the previously stored addr returns the stored value.

Source files
------------

// File: rtl/bsg_test_node_pkg.sv
// Shared FSB test-node definitions: op codes, header field widths and a
// payload struct macro so each node can size its payload from its own params.
`ifndef BSG_TEST_NODE_PKG_SV
`define BSG_TEST_NODE_PKG_SV

// Payload packed from the LSB up: data, addr, tag, op.
`define BSG_TEST_NODE_PAYLOAD_S(data_w, addr_w, tag_w) \
  typedef struct packed { \
    bsg_test_node_pkg::op_e op; \
    logic [(tag_w)-1:0]     tag; \
    logic [(addr_w)-1:0]    addr; \
    logic [(data_w)-1:0]    data; \
  }

package bsg_test_node_pkg;

  localparam int dest_width_gp   = 4;
  localparam int cmd_width_gp    = 1;
  localparam int header_width_gp = dest_width_gp + cmd_width_gp;

  typedef enum logic [1:0] {
    OP_STORE     = 2'b00,
    OP_LOAD      = 2'b01,
    OP_STORE_ACK = 2'b10,
    OP_ERROR     = 2'b11
  } op_e;

  function automatic int payload_width(input int data_w, input int addr_w, input int tag_w);
    return 2 + tag_w + addr_w + data_w;
  endfunction

endpackage

`endif

// File: rtl/bsg_test_node_client_mem_if.sv
// FSB request/response handshake between the master test node and a client.
// The master drives requests and consumes responses; the client does the reverse.
interface bsg_test_node_client_mem_if #(
  parameter int ring_width_p = 80
) ();

  logic                    v_i;
  logic [ring_width_p-1:0] data_i;
  logic                    ready_o;
  logic                    v_o;
  logic [ring_width_p-1:0] data_o;
  logic                    yumi_i;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );

endinterface

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: write or registered read per cycle, no reset.
module bsg_mem_1rw_sync #(
  parameter int width_p = 32,
  parameter int els_p   = 1024,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        mem_r[addr_i] <= data_i;
      end else begin
        data_o <= mem_r[addr_i];
      end
    end
  end

endmodule

// File: rtl/bsg_test_node_client_mem.sv
// Far-end FSB test client: services stores/loads against a private RAM and
// returns one response per request. Define BSG_TEST_NODE_CLIENT_ERR_RESP_EN to answer malformed requests.
module bsg_test_node_client_mem
  import bsg_test_node_pkg::*;
#(
  parameter int ring_width_p = 80,
  parameter int master_id_p  = 0,
  parameter int client_id_p  = 1,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 10,
  parameter int els_p        = 1024,
  parameter int tag_width_p  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  bsg_test_node_client_mem_if.slave  fsb,
  output logic [7:0]                 err_cnt_o
);

  `BSG_TEST_NODE_PAYLOAD_S(data_width_p, addr_width_p, tag_width_p) payload_s;

  localparam int payload_width_lp  = $bits(payload_s);
  localparam int mem_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [addr_width_p:0] els_lp = (addr_width_p + 1)'(els_p);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_e;

  state_e                    state_r, state_n;
  logic [ring_width_p-1:0]   resp_r, resp_n;
  logic [7:0]                err_cnt_r;
  payload_s                  req_payload;
  logic [dest_width_gp-1:0]  req_dest;
  logic                      req_cmd;
  logic                      req_malformed;
  logic                      accept;
  logic                      mem_v;
  logic                      mem_w;
  logic [data_width_p-1:0]   mem_data;
  logic                      unused_req_bits;

  assign req_dest    = fsb.data_i[ring_width_p-1 -: dest_width_gp];
  assign req_cmd     = fsb.data_i[ring_width_p-1-dest_width_gp];
  assign req_payload = payload_s'(fsb.data_i[payload_width_lp-1:0]);

  // Payload bits above op carry no meaning on input.
  assign unused_req_bits = ^fsb.data_i;

  assign req_malformed = (req_dest != dest_width_gp'(client_id_p))
                       | req_cmd
                       | (req_payload.op inside {OP_STORE_ACK, OP_ERROR})
                       | ({1'b0, req_payload.addr} >= els_lp);

  // Reset gates ready_o directly so it drops without waiting for a clock.
  assign fsb.ready_o = reset_n_i & en_i & (state_r == IDLE);
  assign accept      = fsb.v_i & fsb.ready_o;
  assign fsb.v_o     = (state_r == RESP);
  assign fsb.data_o  = resp_r;
  assign err_cnt_o   = err_cnt_r;

  assign mem_v = accept & ~req_malformed;
  assign mem_w = (req_payload.op == OP_STORE);

  bsg_mem_1rw_sync #(
    .width_p (data_width_p),
    .els_p   (els_p)
  ) mem (
    .clk_i  (clk_i),
    .v_i    (mem_v),
    .w_i    (mem_w),
    .addr_i (req_payload.addr[mem_addr_width_lp-1:0]),
    .data_i (req_payload.data),
    .data_o (mem_data)
  );

  function automatic logic [ring_width_p-1:0] make_resp(input op_e op, input payload_s req);
    payload_s                p;
    logic [ring_width_p-1:0] pkt;
    p      = req;
    p.op   = op;
    p.data = '0;
    pkt    = '0;
    pkt[ring_width_p-1 -: dest_width_gp] = dest_width_gp'(master_id_p);
    pkt[payload_width_lp-1:0]            = p;
    return pkt;
  endfunction

  always_comb begin
    state_n = state_r;
    resp_n  = resp_r;
    case (state_r)
      IDLE: begin
        if (accept) begin
          if (req_malformed) begin
`ifdef BSG_TEST_NODE_CLIENT_ERR_RESP_EN
            state_n = RESP;
            resp_n  = make_resp(OP_ERROR, req_payload);
`endif
          end else if (req_payload.op == OP_LOAD) begin
            state_n = READ;
            resp_n  = make_resp(OP_LOAD, req_payload);
          end else begin
            state_n = RESP;
            resp_n  = make_resp(OP_STORE_ACK, req_payload);
          end
        end
      end
      READ: begin
        state_n = RESP;
        resp_n[data_width_p-1:0] = mem_data;
      end
      RESP: begin
        if (fsb.yumi_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      resp_r  <= '0;
    end else begin
      state_r <= state_n;
      resp_r  <= resp_n;
    end
  end

  // Malformed-request counter sticks at 255 instead of wrapping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_cnt_r <= '0;
    end else if (accept && req_malformed && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_bsg_test_node_client_mem.sv
// Self-checking bench for bsg_test_node_client_mem: scoreboard of expected
// responses built from a memory model, plus reset, enable and error-count checks.
module tb_bsg_test_node_client_mem;

  localparam int ring_lp   = 80;
  localparam int master_lp = 0;
  localparam int client_lp = 1;
  localparam int els_lp    = 512;

  typedef struct {
    logic [79:0] pkt;
    int          lat;
  } exp_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        en      = 1'b0;
  logic [7:0]  err_cnt;

  exp_t        sb [$];
  logic [31:0] model_mem [int];
  int          model_err   = 0;
  int          check_count = 0;
  int          pass_count  = 0;
  logic [9:0]  rand_addr [8];

  bsg_test_node_client_mem_if #(.ring_width_p(ring_lp)) fsb ();

  bsg_test_node_client_mem #(
    .ring_width_p (ring_lp),
    .master_id_p  (master_lp),
    .client_id_p  (client_lp),
    .data_width_p (32),
    .addr_width_p (10),
    .els_p        (els_lp),
    .tag_width_p  (8)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (en),
    .fsb       (fsb),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] mk_pkt(input logic [3:0] dest, input logic cmd, input logic [1:0] op,
                                         input logic [7:0] tag, input logic [9:0] addr,
                                         input logic [31:0] data, input logic [22:0] pad);
    return {dest, cmd, pad, op, tag, addr, data};
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and push the response the model predicts for it.
  task automatic applyStimulus(input logic [3:0] dest, input logic cmd, input logic [1:0] op,
                               input logic [7:0] tag, input logic [9:0] addr, input logic [31:0] data);
    exp_t e;
    bit   malformed;
    int   waited = 0;
    while (!fsb.ready_o && waited < 20) begin
      tick();
      waited++;
    end
    if (!fsb.ready_o) begin
      checkOutput("ready_timeout", 80'(fsb.ready_o), 80'(1));
      return;
    end
    fsb.v_i    = 1'b1;
    fsb.data_i = mk_pkt(dest, cmd, op, tag, addr, data, 23'($urandom));
    malformed  = (int'(dest) != client_lp) || cmd || op[1] || (int'(addr) >= els_lp);
    if (malformed) begin
      if (model_err < 255) model_err++;
`ifdef BSG_TEST_NODE_CLIENT_ERR_RESP_EN
      e.pkt = mk_pkt(4'(master_lp), 1'b0, 2'b11, tag, addr, 32'h0, 23'h0);
      e.lat = 1;
      sb.push_back(e);
`endif
    end else if (op == 2'b00) begin
      model_mem[int'(addr)] = data;
      e.pkt = mk_pkt(4'(master_lp), 1'b0, 2'b10, tag, addr, 32'h0, 23'h0);
      e.lat = 1;
      sb.push_back(e);
    end else begin
      e.pkt = mk_pkt(4'(master_lp), 1'b0, 2'b01, tag, addr, model_mem[int'(addr)], 23'h0);
      e.lat = 2;
      sb.push_back(e);
    end
    tick();
    fsb.v_i    = 1'b0;
    fsb.data_i = '0;
  endtask

  // Wait for the next response, compare it, optionally stall, then consume it.
  task automatic collectResponse(input int hold);
    exp_t        e;
    int          waited = 0;
    logic [79:0] held;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 80'(sb.size()), 80'(1));
      return;
    end
    e = sb.pop_front();
    while (!fsb.v_o && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("resp_latency", 80'(waited + 1), 80'(e.lat));
    if (!fsb.v_o) return;
    checkOutput("resp_pkt", fsb.data_o, e.pkt);
    held = fsb.data_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("bp_v", 80'(fsb.v_o), 80'(1));
      checkOutput("bp_data", fsb.data_o, held);
      checkOutput("bp_ready", 80'(fsb.ready_o), 80'(0));
    end
    fsb.yumi_i = 1'b1;
    tick();
    fsb.yumi_i = 1'b0;
    checkOutput("post_yumi_v", 80'(fsb.v_o), 80'(0));
    checkOutput("post_yumi_ready", 80'(fsb.ready_o), 80'(en));
  endtask

  task automatic checkQuiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      checkOutput("no_resp_v", 80'(fsb.v_o), 80'(0));
    end
  endtask

  task automatic malformedOne(input logic [3:0] dest, input logic cmd, input logic [1:0] op,
                              input logic [9:0] addr, input logic [7:0] tag);
    applyStimulus(dest, cmd, op, tag, addr, 32'h00000BAD);
`ifdef BSG_TEST_NODE_CLIENT_ERR_RESP_EN
    collectResponse(0);
`else
    checkQuiet(2);
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fsb.v_i    = 1'b0;
    fsb.data_i = '0;
    fsb.yumi_i = 1'b0;
    en         = 1'b1;
    reset_n    = 1'b0;
    #2;
    checkOutput("rst_v", 80'(fsb.v_o), 80'(0));
    checkOutput("rst_ready", 80'(fsb.ready_o), 80'(0));
    checkOutput("rst_data", fsb.data_o, 80'(0));
    checkOutput("rst_err", 80'(err_cnt), 80'(0));
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", 80'(fsb.ready_o), 80'(1));
    tick();

    $display("[TB] store then load of 0x005");
    applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'h11, 10'h005, 32'hDEADBEEF);
    collectResponse(0);
    applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'h22, 10'h005, 32'h0);
    collectResponse(0);

    $display("[TB] backpressure and top-of-memory address");
    applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'h33, 10'h1FF, 32'hCAFEF00D);
    collectResponse(10);
    applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'h34, 10'h1FF, 32'h0);
    collectResponse(3);
    applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'h35, 10'h000, 32'h12345678);
    collectResponse(0);

    $display("[TB] random store/load pairs");
    for (int i = 0; i < 8; i++) begin
      rand_addr[i] = 10'($urandom_range(1, els_lp - 2));
      applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'($urandom), rand_addr[i], $urandom);
      collectResponse(0);
    end
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'($urandom), rand_addr[i], 32'h0);
      collectResponse(0);
    end

    $display("[TB] enable low blocks acceptance");
    applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'h40, 10'h010, 32'hAAAA5555);
    collectResponse(0);
    en = 1'b0;
    #1;
    checkOutput("en_low_ready", 80'(fsb.ready_o), 80'(0));
    fsb.v_i    = 1'b1;
    fsb.data_i = mk_pkt(4'(client_lp), 1'b0, 2'b00, 8'h41, 10'h010, 32'h0000BBBB, 23'h0);
    checkQuiet(3);
    fsb.v_i    = 1'b0;
    fsb.data_i = '0;
    en = 1'b1;
    applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'h42, 10'h011, 32'h01010101);
    en = 1'b0;
    collectResponse(2);
    tick();
    checkOutput("en_low_after_resp", 80'(fsb.ready_o), 80'(0));
    en = 1'b1;
    applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'h43, 10'h010, 32'h0);
    collectResponse(0);

    $display("[TB] malformed requests");
    malformedOne(4'(client_lp + 1), 1'b0, 2'b00, 10'h007, 8'h50);
    malformedOne(4'(client_lp), 1'b0, 2'b00, 10'(els_lp), 8'h51);
    malformedOne(4'(client_lp), 1'b0, 2'b11, 10'h007, 8'h52);
    checkOutput("err_cnt_3", 80'(err_cnt), 80'(3));
    applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'h53, 10'h000, 32'h0);
    collectResponse(0);

    $display("[TB] malformed stream to saturation");
    for (int i = 0; i < 300; i++) begin
      case (i % 4)
        0: applyStimulus(4'(client_lp + 2), 1'b0, 2'b01, 8'(i), 10'h020, 32'h0);
        1: applyStimulus(4'(client_lp), 1'b1, 2'b00, 8'(i), 10'h020, 32'h0);
        2: applyStimulus(4'(client_lp), 1'b0, 2'b10, 8'(i), 10'h020, 32'h0);
        default: applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'(i), 10'(els_lp + i), 32'h0);
      endcase
`ifdef BSG_TEST_NODE_CLIENT_ERR_RESP_EN
      collectResponse(0);
`endif
      if (i == 248) checkOutput("err_cnt_252", 80'(err_cnt), 80'(252));
    end
    checkQuiet(1);
    checkOutput("err_cnt_sat", 80'(err_cnt), 80'(255));

    $display("[TB] reset during response");
    applyStimulus(4'(client_lp), 1'b0, 2'b00, 8'h60, 10'h040, 32'h0BADCAFE);
    checkOutput("pre_rst_v", 80'(fsb.v_o), 80'(1));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_v", 80'(fsb.v_o), 80'(0));
    checkOutput("mid_rst_ready", 80'(fsb.ready_o), 80'(0));
    checkOutput("mid_rst_data", fsb.data_o, 80'(0));
    checkOutput("mid_rst_err", 80'(err_cnt), 80'(0));
    sb.delete(0);
    model_err = 0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    checkOutput("rel_ready", 80'(fsb.ready_o), 80'(en));
    tick();
    applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'h61, 10'h040, 32'h0);
    collectResponse(0);
    applyStimulus(4'(client_lp), 1'b0, 2'b01, 8'h62, 10'h005, 32'h0);
    collectResponse(0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
